seq_mult: RTL and testbench

// Parametrised sequential shift-add multiplier with integrated controller and datapath.

---
 rtl/seq_mult_pkg.sv | 19 +
 rtl/seq_mult_ctl.sv | 75 +++++++
 rtl/seq_mult.sv | 70 +++++++
 tb/tb_seq_mult.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared types and magnitude helper for the sequential multiplier
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int MAX_W = 64;

   // Callers zero-extend a WIDTH-bit operand and truncate the result back to WIDTH bits,
   // so the negation is correct modulo 2^WIDTH (the most negative value maps to 2^(WIDTH-1)).
   function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

endpackage

// File: rtl/seq_mult_ctl.sv
// rtl/seq_mult_ctl.sv - controller: state register, iteration counter, handshakes and datapath strobes
module seq_mult_ctl
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic in_valid,
   input  logic out_ready,
   output logic in_ready,
   output logic out_valid,
   output logic busy,
   output logic load,
   output logic shift,
   output logic negate
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid)    state_nxt = RUN;
         RUN:  if (cnt == LAST) state_nxt = FIX;
         FIX:                   state_nxt = DONE;
         DONE: if (out_ready)   state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
      if (clear) state_nxt = IDLE;
   end

   // Strobes are gated by clear so an abort never disturbs the datapath registers.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      negate    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            load     = in_valid & ~clear;
         end
         RUN: begin
            busy  = 1'b1;
            shift = ~clear;
         end
         FIX: begin
            busy   = 1'b1;
            negate = ~clear;
         end
         DONE: out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)            cnt <= '0;
      else if (clear || load)  cnt <= '0;
      else if (shift)          cnt <= cnt + CNT_W'(1);
   end

endmodule

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - iterative shift-add multiplier, unsigned or signed per transaction
module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   logic load, shift, negate;
   logic neg;
   logic [WIDTH-1:0]   mcand, a_mag, b_mag;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH:0]     sum;

   seq_mult_ctl #(.WIDTH(WIDTH)) u_ctl (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .out_ready (out_ready),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .busy      (busy),
      .load      (load),
      .shift     (shift),
      .negate    (negate)
   );

   always_comb begin
      a_mag = WIDTH'(abs_w(MAX_W'(multiplicand), is_signed & multiplicand[WIDTH-1]));
      b_mag = WIDTH'(abs_w(MAX_W'(multiplier),   is_signed & multiplier[WIDTH-1]));
   end

   // Upper half accumulates with a carry bit that is shifted back into the product.
   always_comb begin
      sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
      if (prod[0]) sum = sum + {1'b0, mcand};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcand <= '0;
         prod  <= '0;
         neg   <= 1'b0;
      end else if (load) begin
         mcand <= a_mag;
         prod  <= {{WIDTH{1'b0}}, b_mag};
         neg   <= is_signed & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
      end else if (shift) begin
         prod  <= {sum, prod[WIDTH-1:1]};
      end else if (negate && neg) begin
         prod  <= -prod;
      end
   end

   assign product = prod;

endmodule

// File: tb/tb_seq_mult.sv
// tb/tb_seq_mult.sv - directed self-checking bench for seq_mult at WIDTH=32 and WIDTH=4
module tb_seq_mult;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;

   logic        clear32 = 1'b0, in_valid32 = 1'b0, sgn32 = 1'b0, out_ready32 = 1'b0;
   logic [31:0] mcand32 = '0, mult32 = '0;
   logic        in_ready32, out_valid32, busy32;
   logic [63:0] product32;

   logic        clear4 = 1'b0, in_valid4 = 1'b0, sgn4 = 1'b0, out_ready4 = 1'b0;
   logic [3:0]  mcand4 = '0, mult4 = '0;
   logic        in_ready4, out_valid4, busy4;
   logic [7:0]  product4;

   int n_checks = 0;
   int n_fail   = 0;
   int lat;

   seq_mult #(.WIDTH(32)) dut32 (
      .clk(clk), .reset_n(reset_n), .clear(clear32), .in_valid(in_valid32),
      .in_ready(in_ready32), .is_signed(sgn32), .multiplicand(mcand32),
      .multiplier(mult32), .out_valid(out_valid32), .out_ready(out_ready32),
      .product(product32), .busy(busy32)
   );

   seq_mult #(.WIDTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .clear(clear4), .in_valid(in_valid4),
      .in_ready(in_ready4), .is_signed(sgn4), .multiplicand(mcand4),
      .multiplier(mult4), .out_valid(out_valid4), .out_ready(out_ready4),
      .product(product4), .busy(busy4)
   );

   initial forever #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
      mcand32 = a; mult32 = b; sgn32 = s; in_valid32 = 1'b1;
      tick;
      in_valid32 = 1'b0; mcand32 = 32'hDEAD_BEEF; mult32 = 32'h0BAD_F00D; sgn32 = ~s;
      lat = 0;
      while (!out_valid32 && lat < 100) begin
         tick;
         lat++;
      end
      check("lat32", 64'(lat), 64'd33);
   endtask

   task automatic finish32;
      out_ready32 = 1'b1;
      tick;
      out_ready32 = 1'b0;
      check("idle_after_deliver", {62'd0, in_ready32, out_valid32}, 64'b10);
   endtask

   initial begin
      #2;
      check("rst_in_ready", 64'(in_ready32), 64'd1);
      check("rst_out_valid", 64'(out_valid32), 64'd0);
      check("rst_busy", 64'(busy32), 64'd0);
      check("rst_product", product32, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick;

      // 1: unsigned max
      start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("umax", product32, 64'hFFFF_FFFE_0000_0001);
      finish32;

      // 2: signed corners
      start32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      check("s_m1_m1", product32, 64'h0000_0000_0000_0001);
      finish32;
      start32(32'h8000_0000, 32'h8000_0000, 1'b1);
      check("s_min_min", product32, 64'h4000_0000_0000_0000);
      finish32;
      start32(32'h8000_0000, 32'h0000_0001, 1'b1);
      check("s_min_1", product32, 64'hFFFF_FFFF_8000_0000);
      finish32;
      start32(32'h0000_0000, 32'hFFFF_FFFB, 1'b1);
      check("s_0_m5", product32, 64'd0);
      finish32;

      // clear wins over in_valid in IDLE
      in_valid32 = 1'b1; clear32 = 1'b1;
      tick;
      in_valid32 = 1'b0; clear32 = 1'b0;
      check("clear_vs_accept", {62'd0, in_ready32, busy32}, 64'b10);

      // 3: backpressure
      start32(32'h1234_5678, 32'h0000_0009, 1'b0);
      for (int i = 0; i < 10; i++) begin
         in_valid32 = i[0];
         tick;
         check("bp_product", product32, 64'h0000_0000_A3D7_0A38);
         check("bp_hs", {62'd0, in_ready32, out_valid32}, 64'b01);
      end
      in_valid32 = 1'b0;
      finish32;

      // 4: abort mid-RUN
      mcand32 = 32'd100; mult32 = 32'd3; sgn32 = 1'b0; in_valid32 = 1'b1;
      tick;
      in_valid32 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("abort_run", {62'd0, busy32, out_valid32}, 64'b10);
      end
      clear32 = 1'b1;
      tick;
      clear32 = 1'b0;
      check("abort_idle", {61'd0, in_ready32, busy32, out_valid32}, 64'b100);
      start32(32'd7, 32'd6, 1'b0);
      check("after_abort", product32, 64'd42);
      finish32;

      // 5: async reset mid-RUN
      mcand32 = 32'd55; mult32 = 32'd77; in_valid32 = 1'b1;
      tick;
      in_valid32 = 1'b0;
      tick; tick; tick;
      #2 reset_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy32), 64'd0);
      check("arst_out_valid", 64'(out_valid32), 64'd0);
      check("arst_product", product32, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      tick;
      check("arst_in_ready", 64'(in_ready32), 64'd1);
      start32(32'd3, 32'hFFFF_FFFC, 1'b1);
      check("s_3_m4", product32, 64'hFFFF_FFFF_FFFF_FFF4);
      finish32;

      // 6: WIDTH=4 exhaustive against integer reference
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               int sa, sb;
               logic [7:0] exp4;
               sa = (s == 1 && a >= 8) ? a - 16 : a;
               sb = (s == 1 && b >= 8) ? b - 16 : b;
               exp4 = 8'(sa * sb);
               mcand4 = 4'(a); mult4 = 4'(b); sgn4 = (s == 1); in_valid4 = 1'b1;
               tick;
               in_valid4 = 1'b0;
               lat = 0;
               while (!out_valid4 && lat < 20) begin
                  tick;
                  lat++;
               end
               check($sformatf("ex4_lat s%0d a%0d b%0d", s, a, b), 64'(lat), 64'd5);
               check($sformatf("ex4 s%0d a%0d b%0d", s, a, b), 64'(product4), 64'(exp4));
               out_ready4 = 1'b1;
               tick;
               out_ready4 = 1'b0;
            end
         end
      end
      check("ex4_idle", {62'd0, in_ready4, busy4}, 64'b10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
